// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier family.
// Operand widths up to MAX_W bits are supported by the helper below.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int MAX_W = 64;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Magnitude of a w-bit value held zero-extended in v; -2^(w-1) maps to 2^(w-1).
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                               input int                w,
                                               input logic              sgn);
        logic [MAX_W-1:0] ext;
        logic [MAX_W-1:0] top;
        ext = v;
        top = v >> (w - 1);
        if (sgn && top[0]) begin
            ext = v | ({MAX_W{1'b1}} << w);
            ext = -ext;
        end
        return ext;
    endfunction

endpackage

// File: rtl/mul_seq_n_if.sv
// Operand/result handshake bundle for mul_seq_n.
// master = requester side, slave = the multiplier.
interface mul_seq_n_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic               is_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] res;
    logic               busy;

    modport master (
        output in_valid, op1, op2, is_signed, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, op1, op2, is_signed, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/add_n.sv
// Parametrised W-bit combinational adder used for the accumulate step.
module add_n #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

// File: rtl/mul_seq_n.sv
// Iterative shift-add W x W -> 2W multiplier, one multiplier bit per clock,
// sign handled by multiplying magnitudes and negating the finished product.
module mul_seq_n
    import mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    mul_seq_n_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam int PW    = 2 * WIDTH;

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_res;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;

    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_mplier_sh;
    logic             w_last;
    logic             w_accept;

    assign w_mag1 = WIDTH'(abs_w(MAX_W'(bus.op1), WIDTH, bus.is_signed));
    assign w_mag2 = WIDTH'(abs_w(MAX_W'(bus.op2), WIDTH, bus.is_signed));

    assign w_accept    = (r_state == IDLE) && bus.in_valid;
    assign w_addend    = r_mplier[0] ? (PW'(r_mcand) << r_cnt) : '0;
    assign w_mplier_sh = r_mplier >> 1;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1)) ||
                         (EARLY_EXIT && (w_mplier_sh == '0));
    assign w_prod      = r_neg ? -w_acc_next : w_acc_next;

    add_n #(.W(PW)) u_add (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .o_sum (w_acc_next)
    );

    // NOTE: every next-state path needs a default first, or the case infers a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_next = CALC;
            CALC:    if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_res    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= w_mag1;
            r_mplier <= w_mag2;
            r_neg    <= bus.is_signed & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == CALC) begin
            r_acc    <= w_acc_next;
            r_mplier <= w_mplier_sh;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_res <= w_prod;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == CALC);
    assign bus.res       = r_res;

endmodule

// File: tb/tb_mul_seq_n.sv
// Directed bench for mul_seq_n: a 32-bit fixed-latency unit and an 8-bit
// early-exit unit, with hand-computed products and latencies.
module tb_mul_seq_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mul_seq_n_if #(.WIDTH(32)) a_if ();
    mul_seq_n_if #(.WIDTH(8))  b_if ();

    mul_seq_n #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    mul_seq_n #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ov(input bit u);
        return u ? b_if.out_valid : a_if.out_valid;
    endfunction

    function automatic logic get_ir(input bit u);
        return u ? b_if.in_ready : a_if.in_ready;
    endfunction

    function automatic logic get_busy(input bit u);
        return u ? b_if.busy : a_if.busy;
    endfunction

    function automatic logic [63:0] get_res(input bit u);
        return u ? 64'(b_if.res) : a_if.res;
    endfunction

    task automatic drive(input bit u, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic v);
        if (u) begin
            b_if.in_valid  = v;
            b_if.op1       = a[7:0];
            b_if.op2       = b[7:0];
            b_if.is_signed = s;
        end else begin
            a_if.in_valid  = v;
            a_if.op1       = a;
            a_if.op2       = b;
            a_if.is_signed = s;
        end
    endtask

    task automatic set_ordy(input bit u, input logic v);
        if (u) b_if.out_ready = v;
        else   a_if.out_ready = v;
    endtask

    // Accept one op and wait (bounded) for out_valid; nbad counts cycles with
    // in_ready high or busy low while the op is in flight.
    task automatic run_op(input bit u, input logic [31:0] a, input logic [31:0] b,
                          input logic s, output int lat, output int nbad);
        @(negedge clk);
        drive(u, a, b, s, 1'b1);
        @(posedge clk);
        #1;
        drive(u, a, b, s, 1'b0);
        lat  = 0;
        nbad = 0;
        while (!get_ov(u) && lat < 200) begin
            if (get_ir(u) || !get_busy(u)) nbad++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take(input bit u, input string tag);
        @(negedge clk);
        set_ordy(u, 1'b1);
        @(posedge clk);
        #1;
        set_ordy(u, 1'b0);
        check({tag, "_ovalid_drop"}, 64'(get_ov(u)), 64'd0);
        check({tag, "_iready_back"}, 64'(get_ir(u)), 64'd1);
    endtask

    initial begin
        int          lat;
        int          nbad;
        int          ov_seen;
        logic [63:0] held;

        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        set_ordy(1'b0, 1'b0);
        set_ordy(1'b1, 1'b0);

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(a_if.in_ready),  64'd0);
        check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
        check("rst_busy",      64'(a_if.busy),      64'd0);
        check("rst_res",       a_if.res,            64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(a_if.in_ready), 64'd1);

        // WIDTH=32, fixed latency
        run_op(1'b0, 32'd3, 32'd5, 1'b0, lat, nbad);
        check("u3x5_lat",     64'(lat),  64'd32);
        check("u3x5_inflight", 64'(nbad), 64'd0);
        check("u3x5_res",     a_if.res,  64'h0000_0000_0000_000F);
        take(1'b0, "u3x5");

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, nbad);
        check("umax_res", a_if.res, 64'hFFFF_FFFE_0000_0001);
        take(1'b0, "umax");

        run_op(1'b0, 32'hFFFF_FFF9, 32'd3, 1'b1, lat, nbad);
        check("s_m7x3_lat", 64'(lat), 64'd32);
        check("s_m7x3_res", a_if.res, 64'hFFFF_FFFF_FFFF_FFEB);
        take(1'b0, "s_m7x3");

        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, lat, nbad);
        check("s_minxmin_res", a_if.res, 64'h4000_0000_0000_0000);
        take(1'b0, "s_minxmin");

        // Backpressure: result holds while inputs churn and out_ready stays low
        run_op(1'b0, 32'h8000_0000, 32'd1, 1'b1, lat, nbad);
        check("s_minx1_res", a_if.res, 64'hFFFF_FFFF_8000_0000);
        held = a_if.res;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b0, $urandom, $urandom, i[0], 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        check("bp_res_held",   a_if.res,            held);
        check("bp_res_value",  a_if.res,            64'hFFFF_FFFF_8000_0000);
        check("bp_ovalid",     64'(a_if.out_valid), 64'd1);
        check("bp_in_ready",   64'(a_if.in_ready),  64'd0);
        take(1'b0, "bp");

        // Reset mid-CALC discards the op
        @(negedge clk);
        drive(1'b0, 32'd100, 32'd200, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 32'd100, 32'd200, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",     64'(a_if.busy),      64'd0);
        check("mid_rst_in_ready", 64'(a_if.in_ready),  64'd0);
        check("mid_rst_ovalid",   64'(a_if.out_valid), 64'd0);
        check("mid_rst_res",      a_if.res,            64'd0);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (a_if.out_valid) ov_seen++;
        end
        check("mid_rst_no_pulse", 64'(ov_seen),         64'd0);
        check("mid_rst_idle",     64'(a_if.in_ready),   64'd1);
        run_op(1'b0, 32'd2, 32'd2, 1'b0, lat, nbad);
        check("after_rst_lat", 64'(lat), 64'd32);
        check("after_rst_res", a_if.res, 64'd4);
        take(1'b0, "after_rst");

        // WIDTH=8, early exit
        run_op(1'b1, 32'h7F, 32'h01, 1'b0, lat, nbad);
        check("ee_7fx01_lat", 64'(lat),    64'd1);
        check("ee_7fx01_res", get_res(1'b1), 64'h007F);
        take(1'b1, "ee_7fx01");

        run_op(1'b1, 32'h7F, 32'h80, 1'b0, lat, nbad);
        check("ee_7fx80_lat", 64'(lat),    64'd8);
        check("ee_7fx80_inflight", 64'(nbad), 64'd0);
        check("ee_7fx80_res", get_res(1'b1), 64'h3F80);
        take(1'b1, "ee_7fx80");

        run_op(1'b1, 32'h7F, 32'h00, 1'b0, lat, nbad);
        check("ee_zero_lat", 64'(lat),    64'd1);
        check("ee_zero_res", get_res(1'b1), 64'h0000);
        take(1'b1, "ee_zero");

        run_op(1'b1, 32'hFF, 32'h02, 1'b1, lat, nbad);
        check("ee_sm1x2_lat", 64'(lat),    64'd2);
        check("ee_sm1x2_res", get_res(1'b1), 64'hFFFE);
        take(1'b1, "ee_sm1x2");

        run_op(1'b1, 32'hFF, 32'h00, 1'b1, lat, nbad);
        check("ee_negzero_lat", 64'(lat),    64'd1);
        check("ee_negzero_res", get_res(1'b1), 64'h0000);
        take(1'b1, "ee_negzero");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
